// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder
// Purpose  : Pipelined add/subtract unit. Each slice is built from 4-bit
//            carry-lookahead groups, with a valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int c_SW = WIDTH / STAGES;
    localparam int c_NG = c_SW / 4;

    // Returns {carry into bit 3, carry out, sum[3:0]}
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       c4;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[3], c4, p ^ c};
    endfunction

    logic             r_vld    [STAGES];
    logic [WIDTH-1:0] r_a      [STAGES];
    logic [WIDTH-1:0] r_b      [STAGES];
    logic [WIDTH-1:0] r_s      [STAGES];
    logic             r_c      [STAGES];
    logic             r_ovf;

    logic             w_vld_in [STAGES];
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_s_in   [STAGES];
    logic             w_c_in   [STAGES];
    logic [WIDTH-1:0] w_s_nxt  [STAGES];
    logic             w_c_nxt  [STAGES];
    logic             w_cm     [STAGES];
    logic             w_adv;

    assign w_adv     = !r_vld[STAGES-1] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign co        = r_c[STAGES-1];
    assign ovf       = r_ovf;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [c_SW-1:0]  w_slice;
            logic             w_cout;
            logic             w_cmsb;
            logic [WIDTH-1:0] w_snext;

            // Subtraction is folded in at entry, so later stages only ever add
            if (k == 0) begin : g_first
                assign w_vld_in[k] = in_valid;
                assign w_a_in[k]   = a;
                assign w_b_in[k]   = sub ? ~b : b;
                assign w_c_in[k]   = sub ? 1'b1 : ci;
                assign w_s_in[k]   = '0;
            end else begin : g_next
                assign w_vld_in[k] = r_vld[k-1];
                assign w_a_in[k]   = r_a[k-1];
                assign w_b_in[k]   = r_b[k-1];
                assign w_c_in[k]   = r_c[k-1];
                assign w_s_in[k]   = r_s[k-1];
            end

            always_comb begin : p_slice
                logic [5:0] t;
                logic       cc;
                t       = '0;
                cc      = w_c_in[k];
                w_cmsb  = 1'b0;
                w_slice = '0;
                for (int j = 0; j < c_NG; j++) begin
                    t = cla4(w_a_in[k][k*c_SW + 4*j +: 4], w_b_in[k][k*c_SW + 4*j +: 4], cc);
                    w_slice[4*j +: 4] = t[3:0];
                    w_cmsb = t[5];
                    cc     = t[4];
                end
                w_cout = cc;
            end

            always_comb begin : p_merge
                w_snext = w_s_in[k];
                w_snext[k*c_SW +: c_SW] = w_slice;
            end

            assign w_s_nxt[k] = w_snext;
            assign w_c_nxt[k] = w_cout;
            assign w_cm[k]    = w_cmsb;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i] <= 1'b0;
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_s[i]   <= '0;
                r_c[i]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i] <= w_vld_in[i];
                r_a[i]   <= w_a_in[i];
                r_b[i]   <= w_b_in[i];
                r_s[i]   <= w_s_nxt[i];
                r_c[i]   <= w_c_nxt[i];
            end
            r_ovf <= w_cm[STAGES-1] ^ w_c_nxt[STAGES-1];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_pipe_adder
// Purpose  : Three adder configurations (32/2, 64/4, 8/1) checked against an
//            arithmetic reference model through a per-beat scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  iv    = '0;
    logic [2:0]  ord   = '1;
    logic [63:0] a     = '0;
    logic [63:0] b     = '0;
    logic        ci    = 1'b0;
    logic        sub   = 1'b0;
    wire  [2:0]  rdy;
    wire  [2:0]  ov;
    wire  [2:0]  oco;
    wire  [2:0]  oovf;
    wire  [31:0] s32;
    wire  [63:0] s64;
    wire  [7:0]  s8;
    wire  [63:0] osum [3];

    assign osum[0] = {32'd0, s32};
    assign osum[1] = s64;
    assign osum[2] = {56'd0, s8};

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(32), .STAGES(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
        .a(a[31:0]), .b(b[31:0]), .ci(ci), .sub(sub), .out_valid(ov[0]),
        .out_ready(ord[0]), .sum(s32), .co(oco[0]), .ovf(oovf[0]));
    cla_pipe_adder #(.WIDTH(64), .STAGES(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(ov[1]),
        .out_ready(ord[1]), .sum(s64), .co(oco[1]), .ovf(oovf[1]));
    cla_pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
        .a(a[7:0]), .b(b[7:0]), .ci(ci), .sub(sub), .out_valid(ov[2]),
        .out_ready(ord[2]), .sum(s8), .co(oco[2]), .ovf(oovf[2]));

    typedef struct {
        int          dut;
        logic [63:0] sum;
        logic        co;
        logic        ovf;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          lat_chk = 1'b1;
    bit          dir_en  = 1'b0;
    logic [63:0] dir_sum = '0;
    logic        dir_co  = 1'b0;
    logic        dir_ovf = 1'b0;
    int          wid [3] = '{32, 64, 8};
    int          lat [3] = '{2, 4, 1};

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Result of the beat on the input bus, as seen by a WIDTH-bit adder
    function automatic exp_t model(int i);
        logic [64:0] mask;
        logic [64:0] am;
        logic [64:0] bp;
        logic [64:0] full;
        logic [63:0] s;
        exp_t        e;
        mask   = (65'd1 << wid[i]) - 65'd1;
        am     = {1'b0, a} & mask;
        bp     = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        full   = am + bp + (sub ? 65'd1 : {64'd0, ci});
        s      = full[63:0] & mask[63:0];
        e.dut  = i;
        e.sum  = s;
        e.co   = full[wid[i]];
        e.ovf  = (am[wid[i]-1] == bp[wid[i]-1]) && (s[wid[i]-1] != am[wid[i]-1]);
        e.cyc  = cyc;
        e.lat  = lat_chk;
        return e;
    endfunction

    function automatic int pending(int i);
        int n = 0;
        foreach (q[m]) if (q[m].dut == i) n++;
        return n;
    endfunction

    task automatic check_out(int i);
        int idx = -1;
        foreach (q[m]) if (idx < 0 && q[m].dut == i) idx = m;
        total++;
        assert (idx >= 0) else begin
            bad++;
            $error("FAIL unexpected_beat dut=%0d observed=%0h expected=none", i, osum[i]);
        end
        if (idx >= 0) begin
            chk($sformatf("sum_d%0d", i), osum[i], q[idx].sum);
            chk($sformatf("co_d%0d", i), {63'd0, oco[i]}, {63'd0, q[idx].co});
            chk($sformatf("ovf_d%0d", i), {63'd0, oovf[i]}, {63'd0, q[idx].ovf});
            if (q[idx].lat) chk($sformatf("latency_d%0d", i), 64'(cyc - q[idx].cyc), 64'(lat[i]));
            q.delete(idx);
        end
    endtask

    // One clock: record handshakes that complete at the coming edge, then advance
    task automatic step(output logic [2:0] acc);
        #1;
        acc = iv & rdy;
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) begin
                exp_t e;
                e = model(i);
                if (dir_en) begin
                    e.sum = dir_sum;
                    e.co  = dir_co;
                    e.ovf = dir_ovf;
                end
                q.push_back(e);
            end
            if (ov[i] && ord[i]) check_out(i);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_beat();
        a   = {$urandom(), $urandom()};
        b   = {$urandom(), $urandom()};
        ci  = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic send1(int i);
        logic [2:0] acc;
        int g = 0;
        acc   = '0;
        iv[i] = 1'b1;
        while (!acc[i] && g < 50) begin
            step(acc);
            g++;
        end
        iv[i] = 1'b0;
        chk($sformatf("send_accepted_d%0d", i), {63'd0, acc[i]}, 64'd1);
    endtask

    task automatic stream(int i, int n);
        logic [2:0] acc;
        int sent = 0;
        int g    = 0;
        iv[i] = 1'b1;
        rand_beat();
        while (sent < n && g < 200) begin
            step(acc);
            g++;
            if (acc[i]) begin
                sent++;
                if (sent < n) rand_beat();
            end
        end
        iv[i] = 1'b0;
        chk($sformatf("stream_sent_d%0d", i), 64'(sent), 64'(n));
    endtask

    task automatic drain(int i);
        logic [2:0] acc;
        int g = 0;
        while (pending(i) > 0 && g < 40) begin
            step(acc);
            g++;
        end
        chk($sformatf("drain_d%0d", i), 64'(pending(i)), 64'd0);
    endtask

    task automatic directed(int i, logic [63:0] va, logic [63:0] vb, logic vci, logic vsub,
                            logic [63:0] es, logic ec, logic eo);
        a = va; b = vb; ci = vci; sub = vsub;
        dir_en = 1'b1; dir_sum = es; dir_co = ec; dir_ovf = eo;
        send1(i);
        dir_en = 1'b0;
        drain(i);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation did not complete");
    end

    initial begin
        logic [2:0]  acc;
        logic [63:0] held;
        bit          have;
        held = '0;
        have = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out_valid_d%0d", i), {63'd0, ov[i]}, 64'd0);
            chk($sformatf("rst_in_ready_d%0d", i), {63'd0, rdy[i]}, 64'd1);
            chk($sformatf("rst_sum_d%0d", i), osum[i], 64'd0);
            chk($sformatf("rst_co_d%0d", i), {63'd0, oco[i]}, 64'd0);
            chk($sformatf("rst_ovf_d%0d", i), {63'd0, oovf[i]}, 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All-ones plus one: carry must ripple through every stage boundary
        for (int i = 0; i < 3; i++)
            directed(i, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);

        directed(0, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
        directed(0, 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0);

        // Back-to-back random streams
        for (int i = 0; i < 3; i++) begin
            stream(i, 8);
            drain(i);
        end

        // Backpressure: output must freeze while downstream stalls
        lat_chk = 1'b0;
        ord[0]  = 1'b0;
        iv[0]   = 1'b1;
        rand_beat();
        for (int k = 0; k < 5; k++) begin
            step(acc);
            if (acc[0]) rand_beat();
            if (ov[0]) begin
                chk("stall_in_ready", {63'd0, rdy[0]}, 64'd0);
                if (have) chk("stall_sum_hold", osum[0], held);
                else begin
                    held = osum[0];
                    have = 1'b1;
                end
            end
        end
        chk("stall_out_valid_seen", {63'd0, have}, 64'd1);
        iv[0]  = 1'b0;
        ord[0] = 1'b1;
        stream(0, 3);
        drain(0);
        lat_chk = 1'b1;

        // Reset with beats in flight
        stream(0, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, ov[0]}, 64'd0);
        chk("midrst_in_ready", {63'd0, rdy[0]}, 64'd1);
        for (int n = q.size() - 1; n >= 0; n--)
            if (q[n].dut == 0) q.delete(n);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        directed(0, 64'd3, 64'd4, 1'b1, 1'b0, 64'd8, 1'b0, 1'b0);

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand/sum width; SHALL be a multiple of 4, range 8..128.
REQ-002 Parameter STAGES, default 2: pipeline depth; SHALL divide WIDTH/4 exactly; slice width SW = WIDTH/STAGES.
REQ-003 Port clk  in  1: clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 Port in_valid  in  1: operand beat presented.
REQ-006 Port in_ready  out  1: block accepts a beat when in_valid and in_ready are both high at a clock edge.
REQ-007 Port a, b  in  WIDTH: operands.
REQ-008 Port ci  in  1: carry-in; used only when sub=0.
REQ-009 Port sub  in  1: 0 = a+b+ci; 1 = a-b (a + ~b + 1), with ci ignored.
REQ-010 Port out_valid  out  1: result beat presented.
REQ-011 Port out_ready  in  1: downstream accepts the result when out_valid and out_ready are both high.
REQ-012 Port sum  out  WIDTH: result, modulo 2^WIDTH.
REQ-013 Port co  out  1: carry-out of the MSB (for sub=1, co=1 means no borrow).
REQ-014 Port ovf  out  1: signed two's-complement overflow of the operation.

Function
REQ-015 Adder slices SHALL be built from 4-bit carry-lookahead groups; stage k (0..STAGES-1) SHALL add bits [k*SW +: SW].
REQ-016 Carry SHALL be registered between stages; stage k SHALL use the carry produced by stage k-1 for the same beat.
REQ-017 Upper operand slices SHALL be skew-delayed, and completed lower sum slices deskewed, so that all bits of one beat emerge together.
REQ-018 Latency SHALL be exactly STAGES cycles from acceptance to out_valid, with no stall in between.
REQ-019 Pipeline advance signal adv = !out_valid | out_ready; all stage registers, including valid bits, SHALL move only when adv=1.
REQ-020 in_ready SHALL equal adv (combinational, no dependency on in_valid).
REQ-021 Bubbles (valid=0 stages) SHALL propagate but SHALL NOT be collapsed; throughput SHALL be 1 beat/cycle while out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, sum/co/ovf/out_valid SHALL hold stable.
REQ-023 The sub and ci inputs SHALL be captured with their beat; changing them after acceptance SHALL NOT affect that beat.
REQ-024 ovf SHALL be (carry into MSB) XOR (carry out of MSB) for the beat.
REQ-025 Beats SHALL exit in acceptance order; none SHALL be dropped or duplicated.
REQ-026 Simultaneous accept and output transfer in one cycle SHALL be legal, with no loss.
REQ-027 Data registers of stages whose valid bit is 0 MAY hold any value; outputs SHALL be qualified by out_valid only.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear all valid bits, sum, co, ovf and carry registers to 0.
REQ-029 During reset in_ready SHALL read 1 (out_valid=0); no beat SHALL be accepted while rst_n=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight beats; the first beat accepted after release SHALL emerge after exactly STAGES cycles.

Verification (WIDTH=32, STAGES=2 unless stated)
REQ-031 a=0xFFFF_FFFF, b=0x1, ci=0, sub=0, out_ready=1 -> 2 cycles later sum=0x0, co=1, ovf=0; verifies carry crossing the stage boundary.
REQ-032 a=0x7FFF_FFFF, b=0x1, sub=0 -> sum=0x8000_0000, co=0, ovf=1; then a=0x5, b=0x7, sub=1 -> sum=0xFFFF_FFFE, co=0, ovf=0.
REQ-033 Stream 8 back-to-back random beats with out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching a reference model.
REQ-034 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 once out_valid=1, sum held stable; on release the queued beats drain in order with no loss.
REQ-035 Assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately; after release, a=3, b=4, ci=1 -> sum=8 exactly 2 cycles after acceptance.
REQ-036 Repeat REQ-031 and REQ-033 with WIDTH=64, STAGES=4 (latency 4) and WIDTH=8, STAGES=1 (latency 1).
